// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller.
package fetch_ctrl_pkg;

  localparam int unsigned FC_WIDTH = 16;

  // Opcode field and the absolute-jump opcode handled locally by fetch.
  localparam int unsigned OP_MSB = 15;
  localparam int unsigned OP_LSB = 12;
  localparam logic [3:0]  OP_JMP = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    REDIR = 2'd3
  } state_e;

  function automatic logic is_jmp(input logic [OP_MSB:0] instr);
    return instr[OP_MSB:OP_LSB] == OP_JMP;
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: reads the instruction at PC, presents it to
// execute, and steers the PC with increment (ipc) and load (epc) pulses.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = FC_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc,
  output logic             mem_rd,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_data,
  output logic             ipc,
  output logic             epc,
  output logic [WIDTH-1:0] jdata,
  output logic [WIDTH-1:0] ir,
  output logic             ir_valid,
  input  logic             ir_ready,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [WIDTH-1:0] jdata_q, jdata_d;
  logic             ipc_q, ipc_d;
  logic             epc_q, epc_d;

  // State and pulse registers; reset abandons any in-flight memory read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ir_q    <= '0;
      jdata_q <= '0;
      ipc_q   <= 1'b0;
      epc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      jdata_q <= jdata_d;
      ipc_q   <= ipc_d;
      epc_q   <= epc_d;
    end
  end

  // Next-state logic; ipc/epc are raised only on the transition into
  // ISSUE/REDIR, which makes each a single-cycle pulse and mutually exclusive.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    jdata_d = jdata_q;
    ipc_d   = 1'b0;
    epc_d   = 1'b0;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (mem_ack) begin
          ir_d = mem_data;
          if (is_jmp(mem_data[OP_MSB:0])) begin
            jdata_d = WIDTH'(mem_data[OP_LSB-1:0]);
            epc_d   = 1'b1;
            state_d = REDIR;
          end else begin
            ipc_d   = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (ir_ready) begin
          if (br_taken) begin
            jdata_d = br_target;
            epc_d   = 1'b1;
            state_d = REDIR;
          end else begin
            state_d = FETCH;
          end
        end
      end
      REDIR: state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decode directly from the registered state.
  always_comb begin
    mem_rd   = (state_q == FETCH);
    mem_addr = pc;
    ir_valid = (state_q == ISSUE);
    ir       = ir_q;
    jdata    = jdata_q;
    ipc      = ipc_q;
    epc      = epc_q;
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl with a behavioural PC and instruction memory.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pc = '0;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_data = '0;
  logic        ipc, epc;
  logic [15:0] jdata, ir;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_target = '0;

  fetch_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .pc(pc),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .ipc(ipc), .epc(epc), .jdata(jdata),
    .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .br_taken(br_taken), .br_target(br_target)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_epc;
    logic [15:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mem_ovr[int];

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int unsigned n_accepts = 0;

  // Stimulus configuration
  bit          rnd = 0;
  int unsigned ack_delay = 0;
  int unsigned ready_stall = 0;
  int unsigned br_mode = 0;       // 0 none, 1 once, 2 random
  logic [15:0] br_cfg_tgt = '0;

  // Bench tracking state
  logic [15:0] exp_addr = '0;
  logic [15:0] fetch_addr = '0;
  bit          in_fetch = 0;
  int unsigned wait_cnt = 0, cur_delay = 0;
  int unsigned valid_cnt = 0, cur_stall = 0;
  bit          prev_ipc = 0, prev_epc = 0, prev_valid = 0, prev_accept = 0, prev_ack = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic want_epc, input logic [15:0] got);
    exp_t e;
    check({tag, "_pending"}, 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_kind"}, 32'(e.is_epc), 32'(want_epc));
      check(tag, 32'(got), 32'(e.val));
    end
  endtask

  function automatic logic [15:0] pick_data(input logic [15:0] a);
    logic [3:0] op;
    if (mem_ovr.exists(int'(a))) return mem_ovr[int'(a)];
    if (rnd) begin
      op = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      return {op, 12'($urandom)};
    end
    return 16'h1234 + a;
  endfunction

  // One clock of bench activity: sample at negedge, check, then drive inputs.
  task automatic step();
    logic [15:0] d;
    bit          take, acc;
    logic [15:0] tgt;
    @(negedge clk);
    acc = 0;
    check("ipc_epc_excl", 32'(ipc & epc), 0);
    if (prev_ipc)    check("ipc_single", 32'(ipc), 0);
    if (prev_epc)    check("epc_single", 32'(epc), 0);
    if (prev_accept) check("valid_drop", 32'(ir_valid), 0);
    if (prev_ack)    check("rd_drop", 32'(mem_rd), 0);

    if (epc) sb_check("epc_jdata", 1'b1, jdata);

    if (ir_valid) begin
      if (!prev_valid) begin
        check("ipc_first_issue", 32'(ipc), 1);
        valid_cnt = 0;
        cur_stall = rnd ? $urandom_range(0, 3) : ready_stall;
      end else begin
        check("ipc_only_first", 32'(ipc), 0);
      end
      valid_cnt++;
      if (valid_cnt > cur_stall) begin
        take = 0;
        tgt  = '0;
        if (br_mode == 1) begin
          take = 1; tgt = br_cfg_tgt; br_mode = 0;
        end else if (br_mode == 2) begin
          take = ($urandom_range(0, 2) == 0); tgt = 16'($urandom);
        end
        ir_ready  = 1'b1;
        br_taken  = take;
        br_target = tgt;
        sb_check("ir", 1'b0, ir);
        if (take) begin
          sb.push_back('{is_epc: 1'b1, val: tgt});
          exp_addr = tgt;
        end
        n_accepts++;
        acc = 1;
      end else begin
        ir_ready  = 1'b0;
        br_taken  = 1'($urandom_range(0, 1));
        br_target = 16'($urandom);
      end
    end else begin
      ir_ready  = 1'($urandom_range(0, 1));
      br_taken  = 1'($urandom_range(0, 1));
      br_target = 16'($urandom);
    end

    if (mem_rd) begin
      if (!in_fetch) begin
        in_fetch   = 1;
        wait_cnt   = 0;
        fetch_addr = mem_addr;
        check("fetch_addr", 32'(mem_addr), 32'(exp_addr));
        cur_delay  = rnd ? $urandom_range(0, 2) : ack_delay;
      end else begin
        check("addr_stable", 32'(mem_addr), 32'(fetch_addr));
      end
      if (wait_cnt == cur_delay) begin
        d        = pick_data(fetch_addr);
        mem_ack  = 1'b1;
        mem_data = d;
        in_fetch = 0;
        if (d[15:12] == 4'hF) begin
          sb.push_back('{is_epc: 1'b1, val: {4'h0, d[11:0]}});
          exp_addr = {4'h0, d[11:0]};
        end else begin
          sb.push_back('{is_epc: 1'b0, val: d});
          exp_addr = fetch_addr + 16'd1;
        end
      end else begin
        mem_ack  = 1'b0;
        mem_data = 16'($urandom);
        wait_cnt++;
      end
    end else begin
      in_fetch = 0;
      mem_ack  = 1'($urandom_range(0, 1));
      mem_data = 16'($urandom);
    end

    // Behavioural PC: the DUT's pulses take effect at the coming edge.
    if (epc)      pc = jdata;
    else if (ipc) pc = pc + 16'd1;

    prev_ipc    = ipc;
    prev_epc    = epc;
    prev_valid  = ir_valid;
    prev_accept = acc;
    prev_ack    = mem_ack && mem_rd;
  endtask

  task automatic run_accepts(input int unsigned n, input int unsigned budget);
    int unsigned start;
    start = n_accepts;
    for (int unsigned i = 0; i < budget && n_accepts < start + n; i++) step();
    if (n_accepts < start + n) check("run_timeout", n_accepts - start, n);
  endtask

  task automatic apply_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_mem_rd", 32'(mem_rd), 0);
    check("rst_ir_valid", 32'(ir_valid), 0);
    check("rst_ipc", 32'(ipc), 0);
    check("rst_epc", 32'(epc), 0);
    check("rst_ir", 32'(ir), 0);
    check("rst_jdata", 32'(jdata), 0);
    sb.delete();
    pc = '0; exp_addr = '0; in_fetch = 0;
    mem_ack = 1'b0; ir_ready = 1'b0; br_taken = 1'b0;
    prev_ipc = 0; prev_epc = 0; prev_valid = 0; prev_accept = 0; prev_ack = 0;
    br_mode = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Zero-wait sequential fetch: 0x1234 at address 0, then address 1.
    apply_reset();
    run_accepts(2, 20);

    // Absolute jump at 0: no issue, epc with jdata 0x00A5, refetch there.
    apply_reset();
    mem_ovr[0] = 16'hF0A5;
    run_accepts(1, 20);
    mem_ovr.delete();

    // Execute stalls four cycles, then takes a branch to 0x0200.
    apply_reset();
    ready_stall = 4;
    br_mode = 1; br_cfg_tgt = 16'h0200;
    run_accepts(2, 40);
    ready_stall = 0;

    // Slow memory at the top of the address space; next fetch wraps to 0.
    apply_reset();
    br_mode = 1; br_cfg_tgt = 16'hFFFF;
    run_accepts(1, 20);
    ack_delay = 3;
    run_accepts(2, 40);
    ack_delay = 0;

    // Reset during a pending memory read.
    apply_reset();
    ack_delay = 5;
    for (int i = 0; i < 10 && mem_rd !== 1'b1; i++) step();
    check("reach_fetch", 32'(mem_rd), 1);
    apply_reset();
    ack_delay = 0;

    // Reset in the first issue cycle while ipc is high.
    ready_stall = 3;
    for (int i = 0; i < 10 && ir_valid !== 1'b1; i++) step();
    check("reach_issue", 32'(ir_valid), 1);
    check("ipc_before_rst", 32'(ipc), 1);
    apply_reset();
    ready_stall = 0;
    run_accepts(1, 20);

    // Randomised traffic: delays, stalls, branches, jumps, stray ack/br_taken.
    apply_reset();
    rnd = 1; br_mode = 2;
    for (int i = 0; i < 800; i++) step();
    rnd = 0; br_mode = 0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
